// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_if
// Description : Issue/result bundle between the execute stage and the
//               multiply/divide sequencer (HI/LO owner).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_if;
    logic        flush;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    // Execute-stage side: presents operations, observes hold and results
    modport master (
        output flush, issue_valid, issue_op, src_a, src_b,
        input  stall, busy, done, rd_data, hi, lo
    );

    // Sequencer side
    modport slave (
        input  flush, issue_valid, issue_op, src_a, src_b,
        output stall, busy, done, rd_data, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Multi-cycle multiply/divide sequencer. Fixed-latency product
//               path, radix-2 restoring divider, architectural HI/LO, and
//               pipeline hold / flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MUL_LAT = 2              // 1..8 cycles of multiply occupancy
) (
    input  logic         clk,
    input  logic         rst,              // synchronous, active-low
    muldiv_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [4:0] C_MUL_CNT_INIT = 5'(MUL_LAT - 1);
    localparam logic [4:0] C_DIV_CNT_INIT = 5'd31;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] opa_q,   opa_d;       // multiplicand
    logic [31:0] opb_q,   opb_d;       // multiplier or |divisor|
    logic        msgn_q,  msgn_d;      // signed multiply
    logic [31:0] quot_q,  quot_d;      // dividend shifting out, quotient in
    logic [31:0] rem_q,   rem_d;
    logic        qs_q,    qs_d;        // negate quotient in FIX
    logic        rs_q,    rs_d;        // negate remainder in FIX
    logic        dz_q,    dz_d;        // divide by zero: skip the commit
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        w_accept;
    logic        w_is_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic [32:0] w_rem_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic        w_done_raw;

    assign w_accept = bus.issue_valid && !bus.flush && (state_q == ST_IDLE);
    assign w_is_div = (bus.issue_op == OP_DIV);

    // Magnitudes for signed divide; 0x80000000 stays 0x80000000 as unsigned
    assign w_abs_a = (w_is_div && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
    assign w_abs_b = (w_is_div && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact
    assign w_ma   = {{32{msgn_q & opa_q[31]}}, opa_q};
    assign w_mb   = {{32{msgn_q & opb_q[31]}}, opb_q};
    assign w_prod = w_ma * w_mb;

    // One restoring step: remainder never exceeds the divisor, so 33 bits suffice
    assign w_rem_shift = {rem_q, quot_q[31]};
    assign w_diff      = w_rem_shift - {1'b0, opb_q};
    assign w_ge        = !w_diff[32];

    assign w_q_fix = qs_q ? (~quot_q + 32'd1) : quot_q;
    assign w_r_fix = rs_q ? (~rem_q  + 32'd1) : rem_q;

    assign w_done_raw = ((state_q == ST_MUL) && (cnt_q == 5'd0)) || (state_q == ST_FIX);

    assign bus.stall   = bus.issue_valid && !bus.flush && (state_q != ST_IDLE);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = w_done_raw && !bus.flush;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = (w_accept && bus.issue_op == OP_MFHI) ? hi_q :
                         (w_accept && bus.issue_op == OP_MFLO) ? lo_q : 32'd0;

    // Next-state: issue decode, multiply countdown, divide iterations, fix-up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        msgn_d  = msgn_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (bus.issue_op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            cnt_d   = C_MUL_CNT_INIT;
                            opa_d   = bus.src_a;
                            opb_d   = bus.src_b;
                            msgn_d  = (bus.issue_op == OP_MULT);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = ST_DIV;
                            cnt_d   = C_DIV_CNT_INIT;
                            quot_d  = w_abs_a;
                            rem_d   = 32'd0;
                            opb_d   = w_abs_b;
                            qs_d    = w_is_div && (bus.src_a[31] ^ bus.src_b[31]);
                            rs_d    = w_is_div && bus.src_a[31];
                            dz_d    = (bus.src_b == 32'd0);
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;  // MFHI/MFLO: read-only
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_IDLE;
                    hi_d    = w_prod[63:32];
                    lo_d    = w_prod[31:0];
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_DIV: begin
                rem_d  = w_ge ? w_diff[31:0] : w_rem_shift[31:0];
                quot_d = {quot_q[30:0], w_ge};
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin  // ST_FIX
                state_d = ST_IDLE;
                if (!dz_q) begin
                    lo_d = w_q_fix;
                    hi_d = w_r_fix;
                end
            end
        endcase

        // Flush discards in-flight work and any same-cycle commit or issue
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            msgn_q  <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            qs_q    <= 1'b0;
            rs_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            msgn_q  <= msgn_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed-vector bench for muldiv_ctrl. The driver pushes
//               expected commits / read data into queues; a monitor pops and
//               compares whenever the DUT pulses done or accepts MFHI/MFLO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } commit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = 32'd0;    // expected architectural HI/LO
    logic [31:0] m_lo = 32'd0;

    commit_t     done_q[$];
    logic [31:0] rd_q[$];
    commit_t     pend;
    logic        pend_valid = 1'b0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: done -> compare HI/LO on the following cycle; accepted MFxx -> rd_data
    always @(negedge clk) begin
        if (pend_valid) begin
            chk({pend.tag, "_hi"}, bus.hi, pend.hi);
            chk({pend.tag, "_lo"}, bus.lo, pend.lo);
            pend_valid = 1'b0;
        end
        if (rst && bus.done) begin
            if (done_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending commit at %0t", $time);
            end else begin
                pend       = done_q.pop_front();
                pend_valid = 1'b1;
            end
        end
        if (rst && bus.issue_valid && !bus.flush && !bus.stall && bus.issue_op[2:1] == 2'b11) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read: got accepted MFxx expected stall at %0t", $time);
            end else begin
                chk("rd_data", bus.rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic move_to(input logic [2:0] op, input logic [31:0] d, input string tag);
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.src_a = d; bus.src_b = 32'd0;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        if (op == OP_MTHI) m_hi = d; else m_lo = d;
    endtask

    task automatic move_from(input logic [2:0] op, input string tag);
        rd_q.push_back((op == OP_MFHI) ? m_hi : m_lo);
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.src_a = 32'd0; bus.src_b = 32'd0;
        @(negedge clk);
        chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
        tick();
        bus.issue_valid = 1'b0;
    endtask

    // Issue a MUL/DIV in cycle 0 and walk it to completion (or to a flush)
    task automatic long_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int flush_at, input logic commit,
                           input logic [31:0] ehi, input logic [31:0] elo, input string tag);
        commit_t it;
        if (flush_at == 0) begin
            it.hi = commit ? ehi : m_hi;
            it.lo = commit ? elo : m_lo;
            it.tag = tag;
            done_q.push_back(it);
            m_hi = it.hi;
            m_lo = it.lo;
        end
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        chk({tag, "_c0_stall"}, {31'd0, bus.stall}, 32'd0);
        chk({tag, "_c0_busy"},  {31'd0, bus.busy},  32'd0);
        tick();
        bus.issue_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c == flush_at) bus.flush = 1'b1;
            @(negedge clk);
            chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (c != flush_at)
                chk({tag, "_done"}, {31'd0, bus.done}, {31'd0, (c == lat)});
            tick();
            if (c == flush_at) begin
                bus.flush = 1'b0;
                chk({tag, "_flush_idle"}, {31'd0, bus.busy}, 32'd0);
                chk({tag, "_flush_hi"}, bus.hi, m_hi);
                chk({tag, "_flush_lo"}, bus.lo, m_lo);
                return;
            end
        end
        chk({tag, "_after_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // Watchdog: the directed sequence is a few hundred cycles
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_op = 3'd0;
        bus.src_a = 32'd0; bus.src_b = 32'd0;

        // Reset state
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_hi",    bus.hi, 32'd0);
        chk("rst_lo",    bus.lo, 32'd0);
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_done",  {31'd0, bus.done},  32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        rst = 1'b1;

        move_from(OP_MFHI, "mfhi_rst");
        move_from(OP_MFLO, "mflo_rst");
        move_to(OP_MTHI, 32'h12345678, "mthi");
        move_from(OP_MFHI, "mfhi_after_mthi");

        long_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, MUL_LAT, 0, 1'b1, 32'h00000001, 32'hFFFFFFFE, "multu");
        long_op(OP_MULT,  32'hFFFFFFFF, 32'd2, MUL_LAT, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        long_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 33, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");

        // DIVU 100/7 with an MFLO held behind it
        begin
            commit_t it;
            it.hi = 32'd2; it.lo = 32'd14; it.tag = "divu_100_7";
            done_q.push_back(it);
            m_hi = 32'd2; m_lo = 32'd14;
            bus.issue_valid = 1'b1; bus.issue_op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
            @(negedge clk);
            chk("divu_c0_stall", {31'd0, bus.stall}, 32'd0);
            tick();
            bus.issue_op = OP_MFLO; bus.src_a = 32'd0; bus.src_b = 32'd0;
            for (int c = 1; c <= 33; c++) begin
                @(negedge clk);
                chk("held_mflo_stall", {31'd0, bus.stall}, 32'd1);
                chk("divu_done", {31'd0, bus.done}, {31'd0, (c == 33)});
                tick();
            end
            rd_q.push_back(32'd14);
            @(negedge clk);
            chk("held_mflo_c34_stall", {31'd0, bus.stall}, 32'd0);
            tick();
            bus.issue_valid = 1'b0;
        end

        long_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 0, 1'b1, 32'h00000000, 32'h80000000, "div_ovf");

        // Flush mid-divide and in the done cycle: HI/LO must hold
        move_to(OP_MTHI, 32'h0000AAAA, "mthi_preset");
        move_to(OP_MTLO, 32'h00005555, "mtlo_preset");
        long_op(OP_DIV, 32'd1000, 32'd3, 33, 10, 1'b1, 32'd1, 32'd333, "div_flush10");
        repeat (40) tick();
        long_op(OP_DIV, 32'd1000, 32'd3, 33, 33, 1'b1, 32'd1, 32'd333, "div_flush_done");
        repeat (5) tick();
        move_from(OP_MFHI, "mfhi_after_flush");

        // MTHI presented together with flush is dropped
        bus.issue_valid = 1'b1; bus.issue_op = OP_MTHI; bus.src_a = 32'hDEADBEEF; bus.flush = 1'b1;
        @(negedge clk);
        chk("mthi_flush_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.issue_valid = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        chk("mthi_flush_hi", bus.hi, 32'h0000AAAA);
        tick();

        // Divide by zero: full sequence, done pulses, HI/LO unchanged
        long_op(OP_DIVU, 32'd5, 32'd0, 33, 0, 1'b0, 32'd0, 32'd0, "divu_by0");

        // Reset pulled during a multiply
        bus.issue_valid = 1'b1; bus.issue_op = OP_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
        tick();
        bus.issue_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mulrst_c1_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        rst = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        @(negedge clk);
        chk("mulrst_hi",    bus.hi, 32'd0);
        chk("mulrst_lo",    bus.lo, 32'd0);
        chk("mulrst_busy",  {31'd0, bus.busy},  32'd0);
        chk("mulrst_done",  {31'd0, bus.done},  32'd0);
        chk("mulrst_stall", {31'd0, bus.stall}, 32'd0);
        chk("mulrst_rd",    bus.rd_data, 32'd0);
        repeat (5) tick();

        chk("scoreboard_drained", done_q.size(), 32'd0);
        chk("rd_queue_drained",   rd_q.size(),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer and HI/LO register owner for the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the decode/execute boundary and runs a radix-2 iterative divider. Multiplies run through a fixed-latency product path. The block holds the pipeline via `stall` while a long operation is in flight, and discards in-flight work on `flush`.

## Interface
- `MUL_LAT`, 2: cycles a multiply occupies the unit after acceptance; legal range 1..8.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-low reset (`rst==0` resets on the next edge).
- `flush` in 1: abort in-flight operation; ignore same-cycle issue.
- `issue_valid` in 1: an operation is presented this cycle.
- `issue_op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `src_a` in 32: rs operand (dividend, multiplicand, MTHI/MTLO data).
- `src_b` in 32: rt operand (divisor, multiplier).
- `stall` out 1: combinational; issue not accepted this cycle, pipeline must hold.
- `busy` out 1: MUL/DIV/FIX operation in flight.
- `done` out 1: one-cycle pulse; HI/LO commit at the end of this cycle.
- `rd_data` out 32: MFHI/MFLO result, valid in the issue cycle when `stall==0`.
- `hi`, `lo` out 32 each: architectural HI/LO.

## Operation
- States: IDLE, MUL, DIV, FIX. Accept condition: `issue_valid && !flush && state==IDLE`.
- `stall = issue_valid && !flush && state!=IDLE`, for every `issue_op`. This includes MFHI/MFLO, so there is no HI/LO forwarding from an in-flight op.
- MTHI/MTLO accepted: `hi`/`lo` written at the end of the issue cycle. The state stays IDLE and `busy` stays 0.
- MFHI/MFLO accepted: `rd_data = hi` or `lo` combinationally. No state change. `rd_data` is 0 when not an accepted MFHI/MFLO.
- MULT/MULTU: IDLE→MUL and latch operands. A 64-bit product is computed, signed (MULT) or unsigned (MULTU). The down-counter starts at MUL_LAT-1. `done` is asserted when the counter hits 0, at which point HI=product[63:32] and LO=product[31:0]. Then MUL→IDLE.
- DIV/DIVU: IDLE→DIV.
  - Latch |a| and |b| (DIV) or the raw values (DIVU), plus sign flags `qs = a[31]^b[31]` and `rs = a[31]` (DIV only).
  - 32 restoring iterations, one per cycle, driven by a 5-bit counter 31→0.
  - DIV→FIX after the last iteration.
  - FIX negates the quotient if `qs`, and the remainder if `rs`. It asserts `done` and commits LO=quotient, HI=remainder. Then FIX→IDLE.
- Divide by zero (`src_b==0`): the full sequence still runs, `done` still pulses, and HI/LO are left unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception.
- `flush` in any cycle: state→IDLE at the next edge, no commit, no `done` in later cycles.
  - Flush during the `done` cycle suppresses the commit; flush wins.
  - MTHI/MTLO presented with `flush` are not written.
- Reset (`rst==0`): state IDLE, `hi=lo=0`, `busy=0`, `done=0`, counters 0. `stall` and `rd_data` then follow the combinational rules above.

## Timing
- Cycle 0 is the acceptance cycle.
- MULT/MULTU:
  - `busy=1` in cycles 1..MUL_LAT.
  - `done=1` in cycle MUL_LAT.
  - New HI/LO visible from cycle MUL_LAT+1.
  - Next issue acceptable in cycle MUL_LAT+1.
- DIV/DIVU:
  - `busy=1` in cycles 1..33; iterations in cycles 1..32; FIX in cycle 33.
  - `done=1` in cycle 33.
  - New HI/LO visible from cycle 34.
  - Next issue acceptable in cycle 34.
- MTHI/MTLO: visible in cycle 1. MFHI/MFLO: zero latency.
- Back-to-back: an issue presented in the first idle cycle after `done` is accepted with `stall=0`.
- `stall` depends only on registered state plus `issue_valid`/`flush`. There is no path from `src_a`/`src_b`.

## Test plan
- Reset then MFHI and MFLO → `rd_data=0`, `stall=0`. MTHI 0x12345678 in cycle 0, then MFHI in cycle 1 → `rd_data=0x12345678`.
- MULTU 0xFFFFFFFF×2 with MUL_LAT=2 → `busy` in cycles 1–2, `done` in cycle 2, HI=0x00000001, LO=0xFFFFFFFE in cycle 3. The same operands with MULT → HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 (−7/2) → `done` in cycle 33, LO=0xFFFFFFFD, HI=0xFFFFFFFF in cycle 34. DIVU 100/7 → LO=14, HI=2.
- MFLO held with `issue_valid` during a DIV → `stall=1` in cycles 1–33. The MFLO is accepted in cycle 34 with the new LO, `stall=0`.
- Flush in cycle 10 of a DIV (HI/LO preset 0xAAAA/0x5555) → IDLE in cycle 11, no `done`, HI/LO unchanged. Repeat with flush in the `done` cycle → still no commit.
- DIVU x/0 → full 34-cycle sequence, `done` pulses, HI/LO unchanged. `rst=0` pulled mid-MUL → all outputs at reset values on the next cycle.
